// File: rtl/wb_arbiter_pkg.sv
// ============================================================================
// wb_arbiter_pkg : shared types and constants for the writeback arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

package wb_arbiter_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 5;
  localparam int MAX_LOADS_DEF  = 4;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  typedef struct packed {
    logic                      valid;
    logic [ADDR_WIDTH_DEF-1:0] rd;
    logic [DATA_WIDTH_DEF-1:0] data;
  } wb_req_t;

endpackage

`default_nettype wire

// File: rtl/wb_load_align.sv
// ============================================================================
// wb_load_align : combinational sub-word extraction and sign/zero extension
// of a raw aligned load word. WB_MISALIGN_TRAP_EN adds o_misalign.
// Revision: 1.0
// ============================================================================
`default_nettype none

module wb_load_align
  import wb_arbiter_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_offset,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
`ifdef WB_MISALIGN_TRAP_EN
  ,
  output logic        o_misalign
`endif
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (i_offset)
      2'd0:    byte_sel = i_word[7:0];
      2'd1:    byte_sel = i_word[15:8];
      2'd2:    byte_sel = i_word[23:16];
      default: byte_sel = i_word[31:24];
    endcase
    half_sel = i_offset[1] ? i_word[31:16] : i_word[15:0];

    // Unused funct3 codes fall through to a full-word load.
    case (i_funct3)
      LD_LB:   o_data = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  o_data = {24'd0, byte_sel};
      LD_LH:   o_data = {{16{half_sel[15]}}, half_sel};
      LD_LHU:  o_data = {16'd0, half_sel};
      default: o_data = i_word;
    endcase
  end

`ifdef WB_MISALIGN_TRAP_EN
  always_comb begin
    case (i_funct3)
      LD_LB, LD_LBU: o_misalign = 1'b0;
      LD_LH, LD_LHU: o_misalign = i_offset[0];
      default:       o_misalign = |i_offset;
    endcase
  end
`endif

endmodule

`default_nettype wire

// File: rtl/wb_arbiter.sv
// ============================================================================
// wb_arbiter : merges ALU results and load responses into one registered
// register-file write per cycle; tracks pending loads per register.
// Optional feature macro: WB_MISALIGN_TRAP_EN (adds o_misalign).
// Revision: 1.0
// ============================================================================
`default_nettype none

module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int MAX_LOADS  = MAX_LOADS_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_aluValid,
  input  logic [ADDR_WIDTH-1:0]    i_aluRd,
  input  logic [DATA_WIDTH-1:0]    i_aluData,
  output logic                     o_aluReady,
  input  logic                     i_ldIssue,
  input  logic [ADDR_WIDTH-1:0]    i_ldIssueRd,
  input  logic                     i_ldValid,
  input  logic [ADDR_WIDTH-1:0]    i_ldRd,
  input  logic [DATA_WIDTH-1:0]    i_ldWord,
  input  logic [1:0]               i_ldOffset,
  input  logic [2:0]               i_ldFunct3,
  output logic                     o_wrEn,
  output logic [ADDR_WIDTH-1:0]    o_rdAddr,
  output logic [DATA_WIDTH-1:0]    o_rdData,
  output logic [2**ADDR_WIDTH-1:0] o_busy,
  output logic                     o_ldFull
`ifdef WB_MISALIGN_TRAP_EN
  ,
  output logic                     o_misalign
`endif
);

  localparam int              NREGS   = 2**ADDR_WIDTH;
  localparam int              CNT_W   = $clog2(MAX_LOADS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOADS);

  logic [31:0] ld_data;
  logic        ld_misalign;

  wb_load_align u_align (
    .i_word     (i_ldWord[31:0]),
    .i_offset   (i_ldOffset),
    .i_funct3   (i_ldFunct3),
    .o_data     (ld_data)
`ifdef WB_MISALIGN_TRAP_EN
    ,
    .o_misalign (ld_misalign)
`endif
  );

`ifndef WB_MISALIGN_TRAP_EN
  assign ld_misalign = 1'b0;
`endif

  logic                  hold_valid_q, hold_valid_d;
  logic [ADDR_WIDTH-1:0] hold_rd_q,    hold_rd_d;
  logic [DATA_WIDTH-1:0] hold_data_q,  hold_data_d;
  logic                  wr_en_q,      wr_en_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q,    rd_addr_d;
  logic [DATA_WIDTH-1:0] rd_data_q,    rd_data_d;
  logic                  misalign_q,   misalign_d;
  logic [NREGS-1:0]      busy_q,       busy_d;
  logic [CNT_W-1:0]      cnt_q,        cnt_d;

  logic                  alu_xfer;
  logic                  sel_valid;
  logic                  sel_misalign;
  logic [ADDR_WIDTH-1:0] sel_rd;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [NREGS-1:0]      busy_set, busy_clr;

  assign o_aluReady = i_rst_n & ~hold_valid_q;
  assign alu_xfer   = i_aluValid & o_aluReady;

  // Priority: load response > hold register > live ALU request.
  always_comb begin
    sel_valid    = 1'b0;
    sel_misalign = 1'b0;
    sel_rd       = '0;
    sel_data     = '0;
    hold_valid_d = hold_valid_q;
    hold_rd_d    = hold_rd_q;
    hold_data_d  = hold_data_q;
    if (i_ldValid) begin
      sel_valid    = 1'b1;
      sel_misalign = ld_misalign;
      sel_rd       = i_ldRd;
      sel_data     = DATA_WIDTH'(ld_data);
      if (alu_xfer) begin
        hold_valid_d = 1'b1;
        hold_rd_d    = i_aluRd;
        hold_data_d  = i_aluData;
      end
    end else if (hold_valid_q) begin
      sel_valid    = 1'b1;
      sel_rd       = hold_rd_q;
      sel_data     = hold_data_q;
      hold_valid_d = 1'b0;
    end else if (alu_xfer) begin
      sel_valid = 1'b1;
      sel_rd    = i_aluRd;
      sel_data  = i_aluData;
    end

    wr_en_d    = sel_valid & (sel_rd != '0) & ~sel_misalign;
    misalign_d = sel_valid & sel_misalign;
    rd_addr_d  = sel_valid ? sel_rd   : rd_addr_q;
    rd_data_d  = sel_valid ? sel_data : rd_data_q;
  end

  // Set beats clear on the same bit; x0 is never marked busy.
  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (i_ldIssue && (i_ldIssueRd != '0)) busy_set[i_ldIssueRd] = 1'b1;
    if (i_ldValid)                        busy_clr[i_ldRd]      = 1'b1;
    busy_d = (busy_q & ~busy_clr) | busy_set;

    cnt_d = cnt_q;
    if (i_ldIssue && !i_ldValid && (cnt_q != CNT_MAX))
      cnt_d = cnt_q + CNT_W'(1);
    else if (i_ldValid && !i_ldIssue && (cnt_q != '0))
      cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      hold_valid_q <= 1'b0;
      hold_rd_q    <= '0;
      hold_data_q  <= '0;
      wr_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      rd_data_q    <= '0;
      misalign_q   <= 1'b0;
      busy_q       <= '0;
      cnt_q        <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_rd_q    <= hold_rd_d;
      hold_data_q  <= hold_data_d;
      wr_en_q      <= wr_en_d;
      rd_addr_q    <= rd_addr_d;
      rd_data_q    <= rd_data_d;
      misalign_q   <= misalign_d;
      busy_q       <= busy_d;
      cnt_q        <= cnt_d;
    end
  end

  assign o_wrEn   = wr_en_q;
  assign o_rdAddr = rd_addr_q;
  assign o_rdData = rd_data_q;
  assign o_busy   = busy_q;
  assign o_ldFull = (cnt_q == CNT_MAX);

`ifdef WB_MISALIGN_TRAP_EN
  assign o_misalign = misalign_q;
`else
  logic unused_misalign;
  assign unused_misalign = misalign_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
// ============================================================================
// tb_wb_arbiter : directed stimulus with a write-scoreboard for wb_arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        ld_issue;
  logic [4:0]  ld_issue_rd;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [31:0] ld_word;
  logic [1:0]  ld_offset;
  logic [2:0]  ld_funct3;
  logic        wr_en;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [31:0] busy;
  logic        ld_full;
`ifdef WB_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int n_checks = 0;
  int n_errors = 0;
  wb_req_t exp_q[$];

  always #5 clk = ~clk;

  wb_arbiter dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_aluValid  (alu_valid),
    .i_aluRd     (alu_rd),
    .i_aluData   (alu_data),
    .o_aluReady  (alu_ready),
    .i_ldIssue   (ld_issue),
    .i_ldIssueRd (ld_issue_rd),
    .i_ldValid   (ld_valid),
    .i_ldRd      (ld_rd),
    .i_ldWord    (ld_word),
    .i_ldOffset  (ld_offset),
    .i_ldFunct3  (ld_funct3),
    .o_wrEn      (wr_en),
    .o_rdAddr    (rd_addr),
    .o_rdData    (rd_data),
    .o_busy      (busy),
    .o_ldFull    (ld_full)
`ifdef WB_MISALIGN_TRAP_EN
    ,
    .o_misalign  (misalign)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_issue = 1'b0; ld_issue_rd = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_word = '0; ld_offset = '0; ld_funct3 = LD_LW;
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] data);
    wb_req_t e;
    e.valid = 1'b1;
    e.rd    = rd;
    e.data  = data;
    exp_q.push_back(e);
  endtask

  task automatic load(input logic [4:0] rd, input logic [31:0] word,
                      input logic [1:0] off, input logic [2:0] f3);
    ld_valid = 1'b1; ld_rd = rd; ld_word = word; ld_offset = off; ld_funct3 = f3;
  endtask

  // Monitor: every register-file write must match the head of the queue.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wb_req_t e;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_write: got x%0d=0x%08h expected no write", rd_addr, rd_data);
      end else begin
        e = exp_q.pop_front();
        if (rd_addr !== e.rd || rd_data !== e.data) begin
          n_errors++;
          $display("FAIL write: got x%0d=0x%08h expected x%0d=0x%08h",
                   rd_addr, rd_data, e.rd, e.data);
        end
      end
    end
  end

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (3) cyc();
    chk("rst_wrEn",   64'(wr_en),     64'd0);
    chk("rst_rdAddr", 64'(rd_addr),   64'd0);
    chk("rst_rdData", 64'(rd_data),   64'd0);
    chk("rst_busy",   64'(busy),      64'd0);
    chk("rst_ldFull", 64'(ld_full),   64'd0);
    chk("rst_ready",  64'(alu_ready), 64'd0);
    rst_n = 1'b1;
    cyc();
    chk("ready_after_rst", 64'(alu_ready), 64'd1);

    // Plain ALU write.
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hdeadbeef;
    chk("alu_ready", 64'(alu_ready), 64'd1);
    push(5'd3, 32'hdeadbeef);
    cyc(); idle();
    cyc();
    chk("alu_wrEn_single", 64'(wr_en), 64'd0);

    // ALU loses to a load and is parked in the hold register.
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h1;
    load(5'd5, 32'hcafebabe, 2'd0, LD_LW);
    push(5'd5, 32'hcafebabe);
    push(5'd4, 32'h1);
    cyc(); idle();
    chk("hold_ready_low", 64'(alu_ready), 64'd0);
    cyc();
    chk("hold_ready_back", 64'(alu_ready), 64'd1);

    // Sub-word extraction.
    load(5'd10, 32'h8badf00d, 2'd3, LD_LB);  push(5'd10, 32'hffffff8b); cyc();
    load(5'd11, 32'h8badf00d, 2'd1, LD_LBU); push(5'd11, 32'h000000f0); cyc();
    load(5'd12, 32'h8badf00d, 2'd2, LD_LH);  push(5'd12, 32'hffff8bad); cyc();
    load(5'd13, 32'h8badf00d, 2'd0, LD_LHU); push(5'd13, 32'h0000f00d); cyc();
    idle();

    // Scoreboard and in-flight counter.
    ld_issue = 1'b1; ld_issue_rd = 5'd7; cyc();
    ld_issue_rd = 5'd9; cyc();
    idle();
    chk("busy_7_9", 64'(busy), 64'(32'h0000_0280));
    ld_issue = 1'b1; ld_issue_rd = 5'd7;
    load(5'd7, 32'h11111111, 2'd0, LD_LW); push(5'd7, 32'h11111111);
    cyc(); idle();
    chk("busy_set_wins", 64'(busy), 64'(32'h0000_0280));
    ld_issue = 1'b1; ld_issue_rd = 5'd0; cyc(); idle();
    chk("busy_x0", 64'(busy[0]), 64'd0);
    chk("not_full_3", 64'(ld_full), 64'd0);
    ld_issue = 1'b1; ld_issue_rd = 5'd1; cyc(); idle();
    chk("full_4", 64'(ld_full), 64'd1);
    load(5'd7, 32'h7, 2'd0, LD_LW); push(5'd7, 32'h7); cyc();
    load(5'd9, 32'h9, 2'd0, LD_LW); push(5'd9, 32'h9); cyc();
    load(5'd1, 32'h1, 2'd0, LD_LW); push(5'd1, 32'h1); cyc();
    chk("not_full_1", 64'(ld_full), 64'd0);
    load(5'd0, 32'h5, 2'd0, LD_LW); cyc(); idle();
    chk("busy_drained", 64'(busy), 64'd0);

    // Write to x0 is dropped without stalling the ALU.
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hffffffff;
    chk("x0_ready", 64'(alu_ready), 64'd1);
    cyc(); idle();
    chk("x0_no_write", 64'(wr_en), 64'd0);
    chk("x0_ready_after", 64'(alu_ready), 64'd1);

    // Misaligned word load.
    ld_issue = 1'b1; ld_issue_rd = 5'd6; cyc(); idle();
    chk("busy_6", 64'(busy[6]), 64'd1);
    load(5'd6, 32'h8badf00d, 2'd2, LD_LW);
`ifndef WB_MISALIGN_TRAP_EN
    push(5'd6, 32'h8badf00d);
`endif
    cyc(); idle();
    chk("busy_6_clr", 64'(busy[6]), 64'd0);
`ifdef WB_MISALIGN_TRAP_EN
    chk("misalign_pulse", 64'(misalign), 64'd1);
    chk("misalign_no_wr", 64'(wr_en), 64'd0);
    cyc();
    chk("misalign_low", 64'(misalign), 64'd0);
`else
    cyc();
`endif

    // Reset while the hold register is occupied.
    alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'h88;
    ld_issue = 1'b1; ld_issue_rd = 5'd12;
    load(5'd2, 32'h22, 2'd0, LD_LW); push(5'd2, 32'h22);
    cyc(); idle();
    chk("busy_12", 64'(busy[12]), 64'd1);
    chk("hold_full", 64'(alu_ready), 64'd0);
    rst_n = 1'b0;
    cyc();
    chk("mid_rst_wrEn",   64'(wr_en),   64'd0);
    chk("mid_rst_rdAddr", 64'(rd_addr), 64'd0);
    chk("mid_rst_rdData", 64'(rd_data), 64'd0);
    chk("mid_rst_busy",   64'(busy),    64'd0);
    chk("mid_rst_full",   64'(ld_full), 64'd0);
    rst_n = 1'b1;
    cyc();
    chk("mid_rst_hold_empty", 64'(alu_ready), 64'd1);
    repeat (3) cyc();

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Writeback stage directly upstream of the register file; owns its single write port. Merges two producers, the single-cycle ALU result and out-of-order-timed load responses from the data memory, into one registered write per cycle. Load responses get sub-word extraction. Keeps a per-register pending-load scoreboard that the hazard unit uses for load-use stalls.

Parameters:
DATA_WIDTH, 32, register data width (load extraction logic is fixed at 32)
ADDR_WIDTH, 5, register address width; scoreboard has 2**ADDR_WIDTH bits
MAX_LOADS, 4, maximum outstanding loads tracked by the in-flight counter

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst_n  in  1  synchronous active-low reset
i_aluValid  in  1  ALU writeback request
i_aluRd  in  ADDR_WIDTH  ALU destination register
i_aluData  in  DATA_WIDTH  ALU result
o_aluReady  out  1  ALU request accepted this cycle when high
i_ldIssue  in  1  load issued to memory this cycle
i_ldIssueRd  in  ADDR_WIDTH  destination of the issued load
i_ldValid  in  1  load response valid; never stalled
i_ldRd  in  ADDR_WIDTH  destination of the responding load
i_ldWord  in  DATA_WIDTH  raw aligned memory word
i_ldOffset  in  2  byte address bits [1:0]
i_ldFunct3  in  3  load type
o_wrEn  out  1  register file write enable
o_rdAddr  out  ADDR_WIDTH  register file write address
o_rdData  out  DATA_WIDTH  register file write data
o_busy  out  2**ADDR_WIDTH  pending-load scoreboard; bit r high means a load to xr is outstanding
o_ldFull  out  1  in-flight load count equals MAX_LOADS

Behaviour:
- Reset (i_rst_n low at edge): o_wrEn=0, o_rdAddr=0, o_rdData=0, scoreboard=0, in-flight count=0, hold register empty. o_aluReady = i_rst_n & ~holdFull, so it is low during reset.
- Per-cycle source priority: load response > hold register > live ALU request.
- ALU handshake: a transfer occurs when i_aluValid & o_aluReady.
  - Transferred request wins the port (no load, hold empty): written directly.
  - Transferred request loses to a load: captured into the 1-entry hold register.
  - Hold full: o_aluReady low. Hold drains on the first cycle without i_ldValid.
  - The hold register and a new ALU transfer are never accepted in the same cycle.
- Latency: the winning source is registered. o_wrEn/o_rdAddr/o_rdData are valid the cycle after selection and are high for exactly one cycle per write. The register file performs the write on the following edge; its write-through supplies same-cycle readers.
- x0: any selected write with rd==0 drives o_wrEn=0. The slot is still consumed, and the hold register still drains.
- Load extraction: byte = word>>(8*offset[1:0]); half = word>>(16*offset[1]).
  - LB (000): sign-extend byte. LBU (100): zero-extend byte.
  - LH (001): sign-extend half. LHU (101): zero-extend half.
  - LW (010): word. Codes 011, 110, 111 are treated as LW.
- Scoreboard:
  - i_ldIssue sets bit i_ldIssueRd, except bit 0, which is never set.
  - i_ldValid clears bit i_ldRd.
  - Simultaneous set and clear of the same bit: set wins.
- In-flight counter:
  - +1 on issue, -1 on response, unchanged on both.
  - Issue while o_ldFull, or response at count 0, is an upstream protocol error. The counter saturates at MAX_LOADS and 0 respectively.
- Upstream guarantees no ALU write to a register whose o_busy bit is set (WAW is ordered by the hazard unit).

Optional Feature:
Macro WB_MISALIGN_TRAP_EN.
- Defined:
  - Adds output o_misalign (1 bit, reset 0).
  - A load response with LH/LHU and offset[0]=1, or LW with offset!=0, is misaligned.
  - A misaligned response produces no register write and pulses o_misalign high for one cycle, aligned with where o_wrEn would have been.
  - The scoreboard bit and the in-flight counter are still cleared/decremented.
  - The slot is still consumed, so the hold register does not drain that cycle.
- Undefined: port absent. Halfword extraction uses offset[1] only and LW ignores the offset.

Decomposition:
- Shared package holds:
  - load funct3 encodings (LB/LH/LW/LBU/LHU)
  - DATA_WIDTH/ADDR_WIDTH defaults
  - a writeback-request struct {valid, rd, data}
- One natural sub-module: wb_load_align, purely combinational extraction/extension (plus misalign flag when enabled).
- Scoreboard, hold register and output register stay in the top.

Test Plan:
- ALU valid rd=3 data=0xdeadbeef, no load -> o_aluReady=1; next cycle o_wrEn=1, o_rdAddr=3, o_rdData=0xdeadbeef, then low.
- Same cycle ALU rd=4 data=0x1 and load rd=5 LW word=0xcafebabe -> cycle+1 writes x5=0xcafebabe. Cycle+2 writes x4=0x1. o_aluReady low during cycle+1.
- Load responses on word 0x8badf00d:
  - LB off=3 -> 0xffffff8b
  - LBU off=1 -> 0x000000f0
  - LH off=2 -> 0xffff8bad
  - LHU off=0 -> 0x0000f00d
- Issue loads rd=7, then rd=9 -> o_busy bits 7 and 9 set. Response rd=7 with simultaneous issue rd=7 -> bit 7 stays set. Issue x0 -> bit 0 never set. Four issues without response -> o_ldFull=1.
- ALU rd=0 data=0xffffffff -> o_wrEn stays 0, o_aluReady stays 1. Reset asserted mid-hold -> all outputs 0, o_busy=0, hold empty.
- WB_MISALIGN_TRAP_EN: LW off=2 rd=6 -> no write, o_misalign pulse, busy bit 6 cleared. Without the macro -> x6 = raw word.
